// File: rtl/mem_pkg.sv
// Shared constants and types for the memory pipeline stage.
package mem_pkg;

  // Access size / sign encodings carried in funct3.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Memory access sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } mem_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane formatting for stores, load extraction and access fault detection.
module lsu_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic        is_store,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_result,
  output logic        fault
);

  logic [31:0] shifted_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic        misalign_s;
  logic        illegal_s;
  logic        illegal_store_s;

  // Select the addressed byte and halfword out of the returned load word.
  always_comb begin
    shifted_s = load_word >> {addr_lo, 3'b000};
    byte_s    = shifted_s[7:0];
    if (addr_lo[1]) begin
      half_s = load_word[31:16];
    end else begin
      half_s = load_word[15:0];
    end
  end

  // Decode funct3 into lane enables, replicated store data, load result and faults.
  always_comb begin
    be              = 4'b0000;
    wdata           = 32'h0000_0000;
    load_result     = 32'h0000_0000;
    misalign_s      = 1'b0;
    illegal_s       = 1'b0;
    illegal_store_s = 1'b0;
    case (funct3)
      F3_B: begin
        be          = 4'b0001 << addr_lo;
        wdata       = {4{store_data[7:0]}};
        load_result = {{24{byte_s[7]}}, byte_s};
      end
      F3_H: begin
        be          = 4'b0011 << addr_lo;
        wdata       = {2{store_data[15:0]}};
        load_result = {{16{half_s[15]}}, half_s};
        misalign_s  = addr_lo[0];
      end
      F3_W: begin
        be          = 4'b1111;
        wdata       = store_data;
        load_result = load_word;
        misalign_s  = (addr_lo != 2'b00);
      end
      F3_BU: begin
        load_result     = {24'h00_0000, byte_s};
        illegal_store_s = 1'b1;
      end
      F3_HU: begin
        load_result     = {16'h0000, half_s};
        misalign_s      = addr_lo[0];
        illegal_store_s = 1'b1;
      end
      default: begin
        illegal_s = 1'b1;
      end
    endcase
    fault = misalign_s | illegal_s | (is_store & illegal_store_s);
  end

endmodule

// File: rtl/stage_memory.sv
// Pipeline stage 4: data-memory access sequencing and the MEM/WB register.
module stage_memory
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [31:0]           in_alu_out,
  input  logic [31:0]           in_mem_in_data,
  input  logic [4:0]            in_rd,
  input  logic [2:0]            in_funct3,
  input  logic                  in_mem_read,
  input  logic                  in_mem_write,
  input  logic                  in_mem_to_reg,
  input  logic                  in_write_enable,
  output logic                  out_dmem_req,
  output logic                  out_dmem_we,
  output logic [ADDR_WIDTH-1:0] out_dmem_addr,
  output logic [31:0]           out_dmem_wdata,
  output logic [3:0]            out_dmem_be,
  input  logic                  in_dmem_ready,
  input  logic                  in_dmem_rvalid,
  input  logic [31:0]           in_dmem_rdata,
  output logic                  out_stall,
  output logic                  out_mem_fault,
  output logic [4:0]            out_MEMWB_rd,
  output logic                  out_MEMWB_write_enable,
  output logic                  out_MEMWB_mem_to_reg,
  output logic [31:0]           out_MEMWB_out_data
);

  mem_state_t  state_r;
  logic        mem_op_s;
  logic        is_store_s;
  logic        align_fault_s;
  logic        fault_s;
  logic        legal_op_s;
  logic [31:0] load_result_s;

  // A write with read also set is treated as a load.
  assign mem_op_s   = in_valid & (in_mem_read | in_mem_write);
  assign is_store_s = in_mem_write & ~in_mem_read;
  assign fault_s    = mem_op_s & align_fault_s;
  assign legal_op_s = mem_op_s & ~align_fault_s;

  lsu_align u_lsu_align (
    .funct3      (in_funct3),
    .addr_lo     (in_alu_out[1:0]),
    .is_store    (is_store_s),
    .store_data  (in_mem_in_data),
    .load_word   (in_dmem_rdata),
    .be          (out_dmem_be),
    .wdata       (out_dmem_wdata),
    .load_result (load_result_s),
    .fault       (align_fault_s)
  );

  // Upstream is frozen while stalled, so address/data stay stable across REQ.
  assign out_dmem_addr = {in_alu_out[ADDR_WIDTH-1:2], 2'b00};
  assign out_dmem_we   = is_store_s;

  // Request and stall are combinational so an accepted store costs no extra cycle;
  // both are gated by reset so they fall as soon as reset asserts.
  always_comb begin
    out_dmem_req = 1'b0;
    out_stall    = 1'b0;
    case (state_r)
      IDLE: begin
        out_dmem_req = legal_op_s;
        out_stall    = legal_op_s & ~(is_store_s & in_dmem_ready);
      end
      REQ: begin
        out_dmem_req = 1'b1;
        out_stall    = ~(is_store_s & in_dmem_ready);
      end
      RESP: begin
        out_dmem_req = 1'b0;
        out_stall    = ~in_dmem_rvalid;
      end
      default: begin
        out_dmem_req = 1'b0;
        out_stall    = 1'b0;
      end
    endcase
    if (!reset) begin
      out_dmem_req = 1'b0;
      out_stall    = 1'b0;
    end else begin
      out_dmem_req = out_dmem_req;
      out_stall    = out_stall;
    end
  end

  // Access sequencer plus MEM/WB capture; MEM/WB holds whenever the stage stalls.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r                <= IDLE;
      out_mem_fault          <= 1'b0;
      out_MEMWB_rd           <= 5'd0;
      out_MEMWB_write_enable <= 1'b0;
      out_MEMWB_mem_to_reg   <= 1'b0;
      out_MEMWB_out_data     <= 32'h0000_0000;
    end else begin
      out_mem_fault <= 1'b0;
      case (state_r)
        IDLE: begin
          if (fault_s) begin
            out_mem_fault          <= 1'b1;
            out_MEMWB_rd           <= in_rd;
            out_MEMWB_write_enable <= 1'b0;
            out_MEMWB_mem_to_reg   <= in_mem_to_reg;
            out_MEMWB_out_data     <= in_alu_out;
          end else if (legal_op_s) begin
            if (is_store_s) begin
              if (in_dmem_ready) begin
                out_MEMWB_rd           <= in_rd;
                out_MEMWB_write_enable <= 1'b0;
                out_MEMWB_mem_to_reg   <= in_mem_to_reg;
                out_MEMWB_out_data     <= in_alu_out;
              end else begin
                state_r <= REQ;
              end
            end else if (in_dmem_ready) begin
              state_r <= RESP;
            end else begin
              state_r <= REQ;
            end
          end else begin
            out_MEMWB_rd           <= in_rd;
            out_MEMWB_write_enable <= in_write_enable & in_valid;
            out_MEMWB_mem_to_reg   <= in_mem_to_reg;
            out_MEMWB_out_data     <= in_alu_out;
          end
        end
        REQ: begin
          if (in_dmem_ready) begin
            if (is_store_s) begin
              state_r                <= IDLE;
              out_MEMWB_rd           <= in_rd;
              out_MEMWB_write_enable <= 1'b0;
              out_MEMWB_mem_to_reg   <= in_mem_to_reg;
              out_MEMWB_out_data     <= in_alu_out;
            end else begin
              state_r <= RESP;
            end
          end else begin
            state_r <= REQ;
          end
        end
        RESP: begin
          if (in_dmem_rvalid) begin
            state_r                <= IDLE;
            out_MEMWB_rd           <= in_rd;
            out_MEMWB_write_enable <= in_write_enable & in_valid;
            out_MEMWB_mem_to_reg   <= in_mem_to_reg;
            out_MEMWB_out_data     <= load_result_s;
          end else begin
            state_r <= RESP;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/stage_memory.md
Name: stage_memory

Overview:
- Pipeline stage 4. Consumes the execute stage's ALU result, store data, rd and control, and performs loads and stores over a ready/valid data-memory port.
- Owns the MEM/WB pipeline register. It feeds write-back and supplies out_MEMWB_rd, out_MEMWB_write_enable and out_MEMWB_out_data back to the execute stage's forwarding path.
- Asserts out_stall while a memory access is outstanding.

Parameters:
- ADDR_WIDTH, 32, data-memory address width; the low ADDR_WIDTH bits of in_alu_out are used.

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  stage holds a real instruction (0 = bubble)
- in_alu_out  input  32  effective address, or result for non-memory ops
- in_mem_in_data  input  32  store data (already forwarded)
- in_rd  input  5  destination register
- in_funct3  input  3  access size/sign
- in_mem_read  input  1  load
- in_mem_write  input  1  store
- in_mem_to_reg  input  1  write-back selects load data
- in_write_enable  input  1  register write
- out_dmem_req  output  1  request valid
- out_dmem_we  output  1  1 = store
- out_dmem_addr  output  ADDR_WIDTH  word-aligned address (low 2 bits zero)
- out_dmem_wdata  output  32  lane-replicated store data
- out_dmem_be  output  4  byte enables
- in_dmem_ready  input  1  request accepted this cycle
- in_dmem_rvalid  input  1  load data valid
- in_dmem_rdata  input  32  load word
- out_stall  output  1  freeze IF/ID/EX this cycle
- out_mem_fault  output  1  registered one-cycle pulse: misaligned access or illegal funct3
- out_MEMWB_rd  output  5  registered rd
- out_MEMWB_write_enable  output  1  registered write enable
- out_MEMWB_mem_to_reg  output  1  registered
- out_MEMWB_out_data  output  32  registered write-back data (ALU result or extracted load)

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE.
  - All MEMWB outputs and out_mem_fault are 0.
  - out_dmem_req and out_stall drop immediately.
- FSM states: IDLE, REQ, RESP.
- Memory op = in_valid & (in_mem_read | in_mem_write). Both read and write set counts as a load.
- Fault conditions:
  - Halfword with addr[0]=1.
  - Word with addr[1:0]≠0.
  - Load funct3 not in {000, 001, 010, 100, 101}.
  - Store funct3 not in {000, 001, 010}.
- Fault handling:
  - No request is issued.
  - At the next edge: out_mem_fault=1 for one cycle, MEMWB captures out_MEMWB_write_enable=0.
  - out_stall=0.
- IDLE, non-memory op or bubble:
  - Single cycle, no stall.
  - MEMWB captures rd, write_enable & in_valid, mem_to_reg, and in_alu_out.
- IDLE, legal memory op:
  - out_dmem_req=1 combinationally in the same cycle.
  - Store, ready=1: done. MEMWB captures write_enable=0. No stall.
  - Store, ready=0: go to REQ, stall=1.
  - Load, ready=1: go to RESP, stall=1.
  - Load, ready=0: go to REQ, stall=1.
- REQ:
  - req held with identical addr/we/wdata/be; upstream is frozen so inputs are stable.
  - On ready: a store completes (stall=0 that cycle, go to IDLE); a load goes to RESP with stall still 1.
- RESP:
  - req=0, stall=1 until rvalid.
  - On rvalid: stall=0 that cycle, MEMWB captures the extracted load data, go to IDLE.
  - rvalid never coincides with acceptance; it arrives at least 1 cycle after ready.
- rvalid in IDLE or REQ is ignored, including a stale response arriving after reset.
- Store formatting:
  - SB: wdata = {4{b}}, be = 0001 << addr[1:0].
  - SH: wdata = {2{h}}, be = 0011 << addr[1:0].
  - SW: wdata = data, be = 1111.
- Load extraction:
  - Select byte addr[1:0] or half addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- Stall semantics: while out_stall=1, MEMWB registers hold their current values (no bubble). Re-writing the same register value is harmless and preserves forwarding.
- Throughput: best case 1 instruction per cycle for stores and non-memory ops; minimum 2 cycles for a load.

Decomposition:
- Package mem_pkg:
  - funct3 constants: F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - mem_state_t enum: IDLE, REQ, RESP.
- Sub-module lsu_align (combinational), instantiated once:
  - Inputs: funct3, addr[1:0], store data, load word.
  - Outputs: be, wdata, load result, fault.

Test Plan:
- ADD result 0x0000_1234, rd=5, write_enable=1 -> next cycle MEMWB rd=5, data 0x1234, we=1; stall never asserted.
- SB data 0xAB at 0x103, ready=1 same cycle -> req=1, be=1000, wdata=0xABABABAB, addr=0x100; no stall; MEMWB we=0.
- LH at 0x102, ready after 2 cycles, rvalid 3 cycles after acceptance, rdata=0x8001_0000 -> stall for 2+3 cycles, drops in the rvalid cycle; MEMWB data 0xFFFF_8001.
- LBU at 0x101 with rdata=0x0000_F700 -> data 0x0000_00F7; repeat as LB -> 0xFFFF_FFF7.
- LW at 0x102 -> no req; one-cycle out_mem_fault; MEMWB we=0; stall=0.
- reset=0 while in RESP, then release and deliver rvalid -> req/stall low immediately; MEMWB all zero; stale rvalid ignored; next ADD processes normally.
